// File: rtl/vx_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// vx_wb_arbiter_if
// Bundle that connects the two writeback producers (ALU, LSU response), the
// downstream freeze, and the writeback-register inputs to vx_wb_arbiter.
//
//   alu_* / mem_*  producer request: valid, result (NT*32), rd, wb, PC_next,
//                  thread_mask, warp_num; ready is returned by the arbiter
//   wb_stall       downstream freeze
//   out_*          held output entry: valid mask, result, rd, wb, PC_next,
//                  warp_num, src (0 = ALU, 1 = MEM)
//
// Modport slave is the arbiter's view; modport master is the view of the
// surrounding core (producers plus writeback register).
// ---------------------------------------------------------------------------
interface vx_wb_arbiter_if #(
    parameter int NT = 4,
    parameter int NW = 8
);
    localparam int WW = $clog2(NW);

    logic                alu_valid;
    logic                alu_ready;
    logic [NT*32-1:0]    alu_result;
    logic [4:0]          alu_rd;
    logic [1:0]          alu_wb;
    logic [31:0]         alu_PC_next;
    logic [NT-1:0]       alu_thread_mask;
    logic [WW-1:0]       alu_warp_num;

    logic                mem_valid;
    logic                mem_ready;
    logic [NT*32-1:0]    mem_result;
    logic [4:0]          mem_rd;
    logic [1:0]          mem_wb;
    logic [31:0]         mem_PC_next;
    logic [NT-1:0]       mem_thread_mask;
    logic [WW-1:0]       mem_warp_num;

    logic                wb_stall;

    logic [NT-1:0]       out_valid;
    logic [NT*32-1:0]    out_result;
    logic [4:0]          out_rd;
    logic [1:0]          out_wb;
    logic [31:0]         out_PC_next;
    logic [WW-1:0]       out_warp_num;
    logic                out_src;

    modport slave (
        input  alu_valid, alu_result, alu_rd, alu_wb, alu_PC_next,
               alu_thread_mask, alu_warp_num,
        input  mem_valid, mem_result, mem_rd, mem_wb, mem_PC_next,
               mem_thread_mask, mem_warp_num,
        input  wb_stall,
        output alu_ready, mem_ready,
        output out_valid, out_result, out_rd, out_wb, out_PC_next,
               out_warp_num, out_src
    );

    modport master (
        output alu_valid, alu_result, alu_rd, alu_wb, alu_PC_next,
               alu_thread_mask, alu_warp_num,
        output mem_valid, mem_result, mem_rd, mem_wb, mem_PC_next,
               mem_thread_mask, mem_warp_num,
        output wb_stall,
        input  alu_ready, mem_ready,
        input  out_valid, out_result, out_rd, out_wb, out_PC_next,
               out_warp_num, out_src
    );
endinterface

// File: rtl/vx_wb_arbiter.sv
// ---------------------------------------------------------------------------
// vx_wb_arbiter
// Shares the writeback pipeline register between the ALU result path and the
// LSU response path. One producer is granted per cycle; MEM has priority, but
// after STARVE_LIMIT consecutive ALU losses the ALU is forced through. The
// winner is held in a one-entry output stage that freezes on wb_stall.
//
//   clk      core clock
//   reset_n  synchronous active-low reset
//   bus      vx_wb_arbiter_if.slave: producer requests/readies, wb_stall,
//            and the out_* entry feeding the writeback register
// ---------------------------------------------------------------------------
module vx_wb_arbiter #(
    parameter int NT           = 4,
    parameter int NW           = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    vx_wb_arbiter_if.slave    bus
);
    localparam int         WW    = $clog2(NW);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef struct packed {
        logic [NT*32-1:0] result;
        logic [4:0]       rd;
        logic [1:0]       wb;
        logic [31:0]      pc_next;
        logic [NT-1:0]    valid;
        logic [WW-1:0]    warp_num;
        logic             src;
    } entry_t;

    logic        full_q,       full_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    entry_t      entry_q,      entry_d;

    logic        accept;
    logic        grant_alu;
    logic        grant_mem;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        full_d       = full_q;
        starve_cnt_d = starve_cnt_q;
        entry_d      = entry_q;

        // The stage can take a new entry when empty or when the held one is
        // being consumed this cycle (pass-through, no bubble).
        accept    = !full_q || !bus.wb_stall;
        grant_alu = bus.alu_valid && (!bus.mem_valid || (starve_cnt_q == LIMIT));
        grant_mem = bus.mem_valid && !grant_alu;

        if (accept) begin
            if (grant_alu) begin
                full_d           = 1'b1;
                entry_d.result   = bus.alu_result;
                entry_d.rd       = bus.alu_rd;
                entry_d.wb       = bus.alu_wb;
                entry_d.pc_next  = bus.alu_PC_next;
                entry_d.valid    = bus.alu_thread_mask;
                entry_d.warp_num = bus.alu_warp_num;
                entry_d.src      = 1'b0;
            end else if (grant_mem) begin
                full_d           = 1'b1;
                entry_d.result   = bus.mem_result;
                entry_d.rd       = bus.mem_rd;
                entry_d.wb       = bus.mem_wb;
                entry_d.pc_next  = bus.mem_PC_next;
                entry_d.valid    = bus.mem_thread_mask;
                entry_d.warp_num = bus.mem_warp_num;
                entry_d.src      = 1'b1;
            end else begin
                // Drain: only the qualifiers are cleared; payload holds.
                full_d        = 1'b0;
                entry_d.valid = '0;
                entry_d.wb    = '0;
            end

            // Counts consecutive cycles the ALU was waiting and MEM won.
            if (grant_alu || !bus.alu_valid) begin
                starve_cnt_d = 4'd0;
            end else if (grant_mem && (starve_cnt_q < LIMIT)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full_q       <= 1'b0;
            starve_cnt_q <= 4'd0;
            // NOTE: the payload is reset too, not just the qualifiers, because
            // the out_* data ports are architecturally zero after reset.
            entry_q      <= '0;
        end else begin
            full_q       <= full_d;
            starve_cnt_q <= starve_cnt_d;
            entry_q      <= entry_d;
        end
    end

    // Readies are suppressed during reset so nothing pending is taken.
    assign bus.alu_ready    = reset_n && accept && grant_alu;
    assign bus.mem_ready    = reset_n && accept && grant_mem;

    assign bus.out_valid    = entry_q.valid;
    assign bus.out_result   = entry_q.result;
    assign bus.out_rd       = entry_q.rd;
    assign bus.out_wb       = entry_q.wb;
    assign bus.out_PC_next  = entry_q.pc_next;
    assign bus.out_warp_num = entry_q.warp_num;
    assign bus.out_src      = entry_q.src;
endmodule

// File: tb/tb_vx_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vx_wb_arbiter
// Directed table of single-cycle vectors, hand-written multi-cycle sequences
// (reset, reset during stall, zero thread mask), then randomized traffic
// compared against a behavioural model of the arbiter.
// ---------------------------------------------------------------------------
module tb_vx_wb_arbiter;
    localparam int NT    = 4;
    localparam int NW    = 8;
    localparam int WW    = 3;
    localparam int LIMIT = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vx_wb_arbiter_if #(.NT(NT), .NW(NW)) bus ();

    vx_wb_arbiter #(.NT(NT), .NW(NW), .STARVE_LIMIT(LIMIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [NT*32-1:0] result;
        logic [4:0]       rd;
        logic [1:0]       wb;
        logic [31:0]      pc;
        logic [NT-1:0]    mask;
        logic [WW-1:0]    warp;
    } req_t;

    typedef struct {
        bit         av, mv, stall;
        bit         e_ar, e_mr;
        logic [3:0] e_ov;
        logic       e_src;
        logic [1:0] e_wb;
        logic [4:0] e_rd;
    } vec_t;

    int total = 0;
    int bad   = 0;

    req_t alu_req_c, mem_req_c;
    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_alu(input bit v, input req_t r);
        bus.alu_valid       = v;
        bus.alu_result      = r.result;
        bus.alu_rd          = r.rd;
        bus.alu_wb          = r.wb;
        bus.alu_PC_next     = r.pc;
        bus.alu_thread_mask = r.mask;
        bus.alu_warp_num    = r.warp;
    endtask

    task automatic drive_mem(input bit v, input req_t r);
        bus.mem_valid       = v;
        bus.mem_result      = r.result;
        bus.mem_rd          = r.rd;
        bus.mem_wb          = r.wb;
        bus.mem_PC_next     = r.pc;
        bus.mem_thread_mask = r.mask;
        bus.mem_warp_num    = r.warp;
    endtask

    function automatic vec_t row(bit av, bit mv, bit st, bit ar, bit mr,
                                 logic [3:0] ov, logic src, logic [1:0] wb, logic [4:0] rd);
        vec_t v;
        v.av = av; v.mv = mv; v.stall = st; v.e_ar = ar; v.e_mr = mr;
        v.e_ov = ov; v.e_src = src; v.e_wb = wb; v.e_rd = rd;
        return v;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.result = {$urandom(), $urandom(), $urandom(), $urandom()};
        r.rd     = 5'($urandom_range(0, 31));
        r.wb     = 2'($urandom_range(0, 3));
        r.pc     = $urandom();
        r.mask   = 4'($urandom_range(0, 15));
        r.warp   = 3'($urandom_range(0, 7));
        return r;
    endfunction

    // Behavioural model state: what the writeback register should see.
    bit               m_full;
    int               m_losses;
    logic [NT-1:0]    m_ov;
    logic [NT*32-1:0] m_res;
    logic [4:0]       m_rd;
    logic [1:0]       m_wb;
    logic [31:0]      m_pc;
    logic [WW-1:0]    m_warp;
    logic             m_src;

    task automatic model_reset();
        m_full = 0; m_losses = 0; m_ov = '0; m_res = '0; m_rd = '0;
        m_wb = '0; m_pc = '0; m_warp = '0; m_src = 1'b0;
    endtask

    task automatic model_load(input req_t r, input logic src);
        m_full = 1; m_ov = r.mask; m_res = r.result; m_rd = r.rd;
        m_wb = r.wb; m_pc = r.pc; m_warp = r.warp; m_src = src;
    endtask

    initial begin
        bit   a_pend, m_pend;
        req_t a_req, m_req;

        alu_req_c.result = {32'h44, 32'h33, 32'h22, 32'h11};
        alu_req_c.rd     = 5'd5;
        alu_req_c.wb     = 2'd1;
        alu_req_c.pc     = 32'h0000_0104;
        alu_req_c.mask   = 4'b1011;
        alu_req_c.warp   = 3'd3;
        mem_req_c.result = {32'hdd, 32'hcc, 32'hbb, 32'haa};
        mem_req_c.rd     = 5'd7;
        mem_req_c.wb     = 2'd2;
        mem_req_c.pc     = 32'h0000_0208;
        mem_req_c.mask   = 4'b1111;
        mem_req_c.warp   = 3'd6;

        // ---------------- reset with both producers requesting ----------------
        reset_n = 1'b0;
        bus.wb_stall = 1'b0;
        drive_alu(1'b1, alu_req_c);
        drive_mem(1'b1, mem_req_c);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst alu_ready", 128'(bus.alu_ready), 128'(0));
            check("rst mem_ready", 128'(bus.mem_ready), 128'(0));
        end
        check("rst out_valid", 128'(bus.out_valid), 128'(0));
        check("rst out_result", 128'(bus.out_result), 128'(0));
        check("rst out_rd", 128'(bus.out_rd), 128'(0));
        check("rst out_wb", 128'(bus.out_wb), 128'(0));
        check("rst out_PC_next", 128'(bus.out_PC_next), 128'(0));
        check("rst out_warp_num", 128'(bus.out_warp_num), 128'(0));
        check("rst out_src", 128'(bus.out_src), 128'(0));
        reset_n = 1'b1;

        // ---------------- directed table ----------------
        // ALU alone
        vecs.push_back(row(1, 0, 0, 1, 0, 4'b1011, 0, 2'd1, 5'd5));
        // conflict: 4 MEM, 1 ALU, twice
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) vecs.push_back(row(1, 1, 0, 0, 1, 4'b1111, 1, 2'd2, 5'd7));
            vecs.push_back(row(1, 1, 0, 1, 0, 4'b1011, 0, 2'd1, 5'd5));
        end
        // drain: qualifiers clear, rd holds
        vecs.push_back(row(0, 0, 0, 0, 0, 4'b0000, 0, 2'd0, 5'd5));
        // load one MEM (one ALU loss), freeze 3 cycles, release
        vecs.push_back(row(1, 1, 0, 0, 1, 4'b1111, 1, 2'd2, 5'd7));
        for (int j = 0; j < 3; j++) vecs.push_back(row(1, 1, 1, 0, 0, 4'b1111, 1, 2'd2, 5'd7));
        // freeze must not have advanced the loss count: 3 more MEM, then ALU
        for (int j = 0; j < 3; j++) vecs.push_back(row(1, 1, 0, 0, 1, 4'b1111, 1, 2'd2, 5'd7));
        vecs.push_back(row(1, 1, 0, 1, 0, 4'b1011, 0, 2'd1, 5'd5));

        foreach (vecs[i]) begin
            drive_alu(vecs[i].av, alu_req_c);
            drive_mem(vecs[i].mv, mem_req_c);
            bus.wb_stall = vecs[i].stall;
            #1;
            check($sformatf("vec%0d alu_ready", i), 128'(bus.alu_ready), 128'(vecs[i].e_ar));
            check($sformatf("vec%0d mem_ready", i), 128'(bus.mem_ready), 128'(vecs[i].e_mr));
            @(posedge clk); #1;
            check($sformatf("vec%0d out_valid", i), 128'(bus.out_valid), 128'(vecs[i].e_ov));
            check($sformatf("vec%0d out_src", i), 128'(bus.out_src), 128'(vecs[i].e_src));
            check($sformatf("vec%0d out_wb", i), 128'(bus.out_wb), 128'(vecs[i].e_wb));
            check($sformatf("vec%0d out_rd", i), 128'(bus.out_rd), 128'(vecs[i].e_rd));
        end
        check("alu lanes", 128'(bus.out_result), {32'h44, 32'h33, 32'h22, 32'h11});
        check("alu warp", 128'(bus.out_warp_num), 128'(3));
        check("alu pc", 128'(bus.out_PC_next), 128'(32'h104));

        // ---------------- reset while a full entry is frozen ----------------
        drive_alu(1'b0, alu_req_c);
        drive_mem(1'b0, mem_req_c);
        bus.wb_stall = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rst-stall alu_ready", 128'(bus.alu_ready), 128'(0));
        @(posedge clk); #1;
        check("rst-stall out_valid", 128'(bus.out_valid), 128'(0));
        check("rst-stall out_wb", 128'(bus.out_wb), 128'(0));
        reset_n = 1'b1;
        drive_mem(1'b1, mem_req_c);
        #1;
        // Stage is empty after reset, so the stall does not block this request.
        check("post-rst mem_ready", 128'(bus.mem_ready), 128'(1));
        @(posedge clk); #1;
        check("post-rst out_valid", 128'(bus.out_valid), 128'(4'b1111));
        check("post-rst out_src", 128'(bus.out_src), 128'(1));

        // ---------------- zero thread mask still occupies the stage ----------
        bus.wb_stall = 1'b0;
        #1;
        mem_req_c.mask = 4'b0000;
        drive_mem(1'b1, mem_req_c);
        @(posedge clk); #1;
        check("zmask out_valid", 128'(bus.out_valid), 128'(0));
        check("zmask out_wb", 128'(bus.out_wb), 128'(2));
        bus.wb_stall = 1'b1;
        #1;
        check("zmask full blocks", 128'(bus.mem_ready), 128'(0));
        @(posedge clk); #1;

        // ---------------- randomized traffic vs model ----------------
        drive_mem(1'b0, mem_req_c);
        bus.wb_stall = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        a_pend = 0;
        m_pend = 0;
        for (int c = 0; c < 400; c++) begin
            bit rst_v, stall_v, acc, ga, gm;
            if (!a_pend) begin
                a_pend = ($urandom_range(0, 2) != 0);
                a_req  = rnd_req();
            end
            if (!m_pend) begin
                m_pend = ($urandom_range(0, 2) != 0);
                m_req  = rnd_req();
            end
            stall_v = ($urandom_range(0, 3) == 0);
            rst_v   = ($urandom_range(0, 49) != 0);
            reset_n = rst_v;
            bus.wb_stall = stall_v;
            drive_alu(a_pend, a_req);
            drive_mem(m_pend, m_req);

            acc = !m_full || !stall_v;
            ga  = a_pend && (!m_pend || (m_losses == LIMIT));
            gm  = m_pend && !ga;
            #1;
            check("rnd alu_ready", 128'(bus.alu_ready), 128'(rst_v && acc && ga));
            check("rnd mem_ready", 128'(bus.mem_ready), 128'(rst_v && acc && gm));
            @(posedge clk); #1;

            if (!rst_v) begin
                model_reset();
            end else if (acc) begin
                if (a_pend && m_pend && gm) m_losses = (m_losses < LIMIT) ? m_losses + 1 : LIMIT;
                else m_losses = 0;
                if (ga) begin
                    model_load(a_req, 1'b0);
                    a_pend = 0;
                end else if (gm) begin
                    model_load(m_req, 1'b1);
                    m_pend = 0;
                end else begin
                    m_full = 0;
                    m_ov   = '0;
                    m_wb   = '0;
                end
            end

            check("rnd out_valid", 128'(bus.out_valid), 128'(m_ov));
            check("rnd out_result", 128'(bus.out_result), 128'(m_res));
            check("rnd out_rd", 128'(bus.out_rd), 128'(m_rd));
            check("rnd out_wb", 128'(bus.out_wb), 128'(m_wb));
            check("rnd out_PC_next", 128'(bus.out_PC_next), 128'(m_pc));
            check("rnd out_warp_num", 128'(bus.out_warp_num), 128'(m_warp));
            check("rnd out_src", 128'(bus.out_src), 128'(m_src));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vx_wb_arbiter.md
# vx_wb_arbiter

Writeback arbiter for the Vortex SIMT core. It shares the single memory/writeback pipeline register between two producers: the ALU result path and the memory-response (LSU) path. It picks one producer per cycle, with starvation-bounded priority, and holds the winner in a one-entry output stage. That stage honours the downstream freeze, and its outputs drive the writeback register's inputs directly.

## Interface
- NT, 4: threads per warp; data width NT*32.
- NW, 8: warps per core; warp index width WW = clog2(NW).
- STARVE_LIMIT, 4: consecutive ALU losses before ALU is forced to win; range 1..15.
- clk  in  1  core clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_result  in  NT*32  per-thread ALU results.
- alu_rd  in  5  destination register.
- alu_wb  in  2  writeback type (0 = none).
- alu_PC_next  in  32  PC+4 for link writes.
- alu_thread_mask  in  NT  active threads.
- alu_warp_num  in  WW  issuing warp.
- mem_valid, mem_ready, mem_result, mem_rd, mem_wb, mem_PC_next, mem_thread_mask, mem_warp_num: same directions, widths and meanings as the ALU set, for the LSU response path.
- wb_stall  in  1  downstream freeze; the output stage must hold.
- out_valid  out  NT  thread mask of the held entry; all zero when empty.
- out_result  out  NT*32  held data.
- out_rd  out  5  held destination register.
- out_wb  out  2  held writeback type; 0 when empty.
- out_PC_next  out  32  held PC_next.
- out_warp_num  out  WW  held warp.
- out_src  out  1  source of the held entry: 0 = ALU, 1 = MEM.

## Operation
- Output stage: `full` flag plus one entry register.
- `accept = !full || !wb_stall`.
- Grant rules:
  - Only one producer valid: that producer is granted.
  - Both valid: MEM wins, unless `starve_cnt == STARVE_LIMIT`, in which case ALU wins.
  - Neither valid: no grant.
- Handshakes:
  - `mem_ready = accept && grant_mem`; `alu_ready = accept && grant_alu`.
  - A handshake completes when valid && ready.
  - At most one producer is ready in any cycle.
  - ready depends combinationally on the valids and wb_stall only. Producers must hold their request stable while valid && !ready.
- On accept with a grant:
  - The entry loads from the granted producer; `full` ← 1.
  - `out_src` records the granted producer.
  - `out_valid` ← thread_mask, passed unmodified, including an all-zero mask.
- On accept with no grant:
  - `full` ← 0; `out_valid` ← 0; `out_wb` ← 0.
  - Data fields, rd, PC_next and warp hold their last values.
- When `!accept` (full && wb_stall): all state holds, including starve_cnt.
- starve_cnt: 4 bits, updated only when accept = 1.
  - Increments, saturating at STARVE_LIMIT, when alu_valid && mem_valid && MEM is granted.
  - Clears to 0 when ALU is granted or alu_valid = 0.
  - Holds when alu_valid = 1 but neither producer is granted. This cannot occur while alu_valid = 1.

## Timing
- Reset (reset_n = 0 at posedge):
  - full = 0, starve_cnt = 0.
  - out_valid = 0, out_result = 0, out_rd = 0, out_wb = 0, out_PC_next = 0, out_warp_num = 0, out_src = 0.
  - While reset_n = 0: alu_ready = mem_ready = 0.
  - Reset mid-stall discards the held entry. Requests pending at reset are not accepted and must be re-presented.
- Latency: a request accepted at edge N appears on the out_* ports after edge N, i.e. for cycle N+1.
- Throughput: one entry per cycle while wb_stall = 0.
- Back-pressure:
  - full && wb_stall: both ready = 0 and the outputs are frozen.
  - The cycle wb_stall drops: the held entry is consumed, and a new grant may load in the same edge (pass-through, no bubble).
- Ordering: with both producers valid, MEM is taken first. With the default limit, ALU waits at most STARVE_LIMIT accepted cycles, i.e. 4.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles while both producers are valid → both ready = 0; all out_* = 0; out_valid = 0.
- ALU only: alu_valid with rd = 5, warp = 3, mask = 4'b1011, result lanes 0x11..0x44 → alu_ready = 1; next cycle out_valid = 4'b1011, out_rd = 5, out_src = 0.
- Conflict and starvation (STARVE_LIMIT = 4): both producers valid continuously → MEM is granted 4 cycles in a row, ALU on the 5th, and the pattern repeats (4 MEM : 1 ALU).
- Freeze: load an entry, then assert wb_stall for 3 cycles with both producers valid → both ready = 0, out_* unchanged, starve_cnt unchanged.
  - Then drop wb_stall → the next grant loads on the same edge.
- Drain: load one entry, then hold wb_stall = 0 with no requests → next cycle out_valid = 0, out_wb = 0, out_rd holds its old value.
- Reset during stall: a full entry with wb_stall = 1, then assert reset_n = 0 for one cycle → out_valid = 0 and full = 0. A MEM request presented after reset completes 1 cycle later.
